// File: rtl/multi_pkg.sv
// multi_host shared types: FSM states, default sizing, counter width helper.
// Imported by multi_host and multi_piso.
package multi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DONE
    } state_e;

    localparam int DEF_W     = 4;
    localparam int DEF_O_LAT = 1;

    function automatic int cnt_width(input int w, input int lat);
        return $clog2(2 * w + lat + 1);
    endfunction

endpackage

// File: rtl/multi_piso.sv
// Loadable W-in, 2W-deep parallel-in/serial-out shift register.
// Zero-extends on load, shifts right with zero fill, LSB is the serial bit.
module multi_piso
    import multi_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] par_i,
    output logic         bit_o
);

    logic [2*W-1:0] sh_q;
    logic [2*W-1:0] sh_d;

    // next contents: load wins over shift, otherwise hold
    always_comb begin
        sh_d = sh_q;
        if (load_i)
            sh_d = {{W{1'b0}}, par_i};
        else if (shift_i)
            sh_d = {1'b0, sh_q[2*W-1:1]};
    end

    // shift register state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            sh_q <= '0;
        else
            sh_q <= sh_d;
    end

    assign bit_o = sh_q[0];

endmodule

// File: rtl/multi_host.sv
// Parallel-side driver for the bit-serial multiplier core.
// Optional MULTI_HOST_CHECK_EN adds a sticky ERR flag against a reference a*b.
module multi_host
    import multi_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int O_LAT = DEF_O_LAT
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [W-1:0]   IN_A,
    input  logic [W-1:0]   IN_B,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [2*W-1:0] OUT_P,
    output logic           SCLR,
    output logic           A_S,
    output logic           B_S,
`ifdef MULTI_HOST_CHECK_EN
    output logic           ERR,
`endif
    input  logic           O_S
);

    localparam int PW = 2 * W;
    localparam int CW = cnt_width(W, O_LAT);
    localparam logic [CW-1:0] LAST  = CW'(PW + O_LAT - 1);
    localparam logic [CW-1:0] FIRST = CW'(O_LAT);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   p_sh_q;
    logic [PW-1:0]   p_sh_d;
    logic [PW-1:0]   out_p_q;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            sclr_q;
    logic            a_s_q;
    logic            b_s_q;
    logic            load;
    logic            shift;
    logic            last;
    logic            a_bit;
    logic            b_bit;

    assign load   = (state_q == IDLE) && IN_VALID;
    assign shift  = (state_q == CLEAR) || (state_q == SHIFT);
    assign last   = (state_q == SHIFT) && (cnt_q == LAST);
    assign p_sh_d = {O_S, p_sh_q[PW-1:1]};

    multi_piso #(.W(W)) u_piso_a (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .load_i  (load),
        .shift_i (shift),
        .par_i   (IN_A),
        .bit_o   (a_bit)
    );

    multi_piso #(.W(W)) u_piso_b (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .load_i  (load),
        .shift_i (shift),
        .par_i   (IN_B),
        .bit_o   (b_bit)
    );

    // control FSM with bit counter, product deserialiser and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_sh_q      <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            sclr_q      <= 1'b0;
            a_s_q       <= 1'b0;
            b_s_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        in_ready_q <= 1'b0;
                        sclr_q     <= 1'b1;
                        state_q    <= CLEAR;
                    end
                end
                CLEAR: begin
                    sclr_q  <= 1'b0;
                    cnt_q   <= '0;
                    p_sh_q  <= '0;
                    a_s_q   <= a_bit;
                    b_s_q   <= b_bit;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    cnt_q <= cnt_q + CW'(1);
                    a_s_q <= a_bit;
                    b_s_q <= b_bit;
                    if (cnt_q >= FIRST)
                        p_sh_q <= p_sh_d;
                    if (last) begin
                        out_p_q     <= p_sh_d;
                        out_valid_q <= 1'b1;
                        a_s_q       <= 1'b0;
                        b_s_q       <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MULTI_HOST_CHECK_EN
    logic [PW-1:0] ref_q;
    logic          err_q;

    // reference product latched at accept, sticky mismatch flag at completion
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ref_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (load)
                ref_q <= PW'(IN_A) * PW'(IN_B);
            if (last && (p_sh_d != ref_q))
                err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`endif

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_P     = out_p_q;
    assign SCLR      = sclr_q;
    assign A_S       = a_s_q;
    assign B_S       = b_s_q;

endmodule

// File: tb/tb_multi_host.sv
// Randomised self-checking bench for multi_host, W=4, O_LAT=1.
// Serial core modelled as truncated-operand products, one cycle of delay.
module tb_multi_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_p;
    logic       sclr;
    logic       a_s;
    logic       b_s;
    logic       o_s;
    logic       fault = 1'b0;
`ifdef MULTI_HOST_CHECK_EN
    logic       err;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multi_host #(.W(4), .O_LAT(1)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_A      (in_a),
        .IN_B      (in_b),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_P     (out_p),
        .SCLR      (sclr),
        .A_S       (a_s),
        .B_S       (b_s),
`ifdef MULTI_HOST_CHECK_EN
        .ERR       (err),
`endif
        .O_S       (o_s)
    );

    // core model: product bit k depends only on operand bits 0..k
    int     idx;
    longint aa, bb;
    always @(posedge clk or negedge rst_n) begin
        longint na, nb;
        logic   pb;
        if (!rst_n || sclr) begin
            idx <= 0;
            aa  <= 0;
            bb  <= 0;
            o_s <= 1'b0;
        end else begin
            na = aa | (longint'(a_s) << idx);
            nb = bb | (longint'(b_s) << idx);
            pb = 1'(((na * nb) >> idx) & 1);
            if (fault && idx == 2)
                pb = ~pb;
            o_s <= pb;
            aa  <= na;
            bb  <= nb;
            if (idx < 20)
                idx <= idx + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // accept one pair, trace the serial streams, check product and latency
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input bit rdy,
                          input bit pop);
        int n;
        int lat;
        int sc;
        logic [7:0] aseq;
        logic [7:0] bseq;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rdy_wait", in_ready, 1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        out_ready = rdy;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        sc = int'(sclr);
        aseq = '0;
        bseq = '0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
            if (lat >= 2 && lat <= 9) begin
                aseq[lat-2] = a_s;
                bseq[lat-2] = b_s;
            end
            sc += int'(sclr);
        end
        check("latency", lat, 11);
        check("prod", out_p, exp);
        check("aseq", aseq, {4'b0, a});
        check("bseq", bseq, {4'b0, b});
        check("sclr_pulses", sc, 1);
        if (pop) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("pop_valid", out_valid, 0);
            check("pop_ready", in_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] held;
        logic [3:0] ra, rb;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_sclr", sclr, 0);
        check("rst_as_bs", {a_s, b_s}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd3, 4'd5, 8'h0F, 1'b0, 1'b1);
        run_op(4'd15, 4'd15, 8'hE1, 1'b0, 1'b1);
        run_op(4'd0, 4'd9, 8'h00, 1'b0, 1'b1);

        // hold in DONE with a competing operand pair on the input
        run_op(4'd2, 4'd7, 8'h0E, 1'b0, 1'b0);
        held = out_p;
        in_a = 4'd11;
        in_b = 4'd13;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_p", out_p, 8'h0E);
            check("hold_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_ready", in_ready, 1);
        check("rel_valid", out_valid, 0);
        repeat (3) @(negedge clk);
        check("ignored_sclr", sclr, 0);
        check("ignored_valid", out_valid, 0);

        // back-to-back with the input held valid and consumer always ready
        begin
            int n;
            in_a = 4'd3;
            in_b = 4'd5;
            in_valid = 1'b1;
            out_ready = 1'b1;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("b2b_p1", out_p, 8'h0F);
            in_a = 4'd7;
            in_b = 4'd6;
            @(negedge clk);
            check("b2b_idle", in_ready, 1);
            @(negedge clk);
            check("b2b_accept", in_ready, 0);
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("b2b_lat", n, 11);
            check("b2b_p2", out_p, 8'h2A);
            @(negedge clk);
            out_ready = 1'b0;
            check("b2b_done", out_valid, 0);
        end

        // reset asserted mid-SHIFT at cnt=3
        in_a = 4'd9;
        in_b = 4'd13;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_p", out_p, 0);
        check("mid_rst_sclr", sclr, 0);
        check("mid_rst_as_bs", {a_s, b_s}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'd2, 4'd2, 8'h04, 1'b0, 1'b1);

        // random pairs, sometimes with the consumer ready throughout
        for (int i = 0; i < 24; i++) begin
            bit rdy;
            ra = 4'($urandom);
            rb = 4'($urandom);
            rdy = 1'($urandom);
            run_op(ra, rb, 8'(ra) * 8'(rb), rdy, !rdy);
            if (rdy) begin
                @(negedge clk);
                out_ready = 1'b0;
                check("rnd_consumed", out_valid, 0);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

`ifdef MULTI_HOST_CHECK_EN
        check("err_clean", err, 0);
        fault = 1'b1;
        run_op(4'd5, 4'd3, 8'h0B, 1'b0, 1'b0);
        check("err_set", err, 1);
        fault = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        run_op(4'd4, 4'd4, 8'h10, 1'b0, 1'b1);
        check("err_sticky", err, 1);
        rst_n = 1'b0;
        #1;
        check("err_rst", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_host.md
Name: multi_host

Overview:
- Parallel-side driver for the bit-serial multiplier core (serial operand inputs A/B, serial product output O).
- Accepts two W-bit unsigned operands over a valid/ready handshake and clears the core.
- Streams both operands LSB-first on A_S/B_S and deserialises the returned O stream into a 2W-bit product.
- Presents the product on a valid/ready output; this is the parallel-side counterpart to the serial core.

Parameters:
W, 4, operand width in bits; product is 2W bits
O_LAT, 1, cycles from a bit index on A_S/B_S to the same bit index on O_S (core pipeline depth, >=0)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset: one clock; reset is asynchronous and active-low
IN_VALID  input  1  operand pair valid
IN_READY  output  1  high only in IDLE
IN_A  input  W  multiplicand
IN_B  input  W  multiplier
OUT_VALID  output  1  product valid
OUT_READY  input  1  consumer accepts product
OUT_P  output  2W  product
SCLR  output  1  synchronous clear to serial core
A_S  output  1  serial multiplicand bit to core
B_S  output  1  serial multiplier bit to core
O_S  input  1  serial product bit from core

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, IN_READY=1, OUT_VALID=0, OUT_P=0, SCLR=0, A_S=B_S=0, counter=0, shift regs=0.
- FSM states: IDLE, CLEAR, SHIFT, DONE.
- IDLE: IN_READY=1. On IN_VALID: latch IN_A/IN_B zero-extended to 2W into a_sh/b_sh, then go to CLEAR.
- CLEAR (1 cycle): SCLR=1, A_S=B_S=0, cnt<=0, p_sh<=0. Next state is SHIFT.
- SHIFT: runs cnt = 0 .. 2W+O_LAT-1, one cycle per count.
  - A_S=a_sh[0], B_S=b_sh[0]. Both shift right each cycle, zero fill, so zeros are driven once cnt>=2W.
  - When cnt>=O_LAT: p_sh <= {O_S, p_sh[2W-1:1]}, which puts product bit k at p_sh[k] after the final capture.
  - At cnt=2W+O_LAT-1: OUT_P<=final p_sh, OUT_VALID<=1, next state DONE.
- DONE: OUT_VALID=1, OUT_P held stable. On OUT_READY: OUT_VALID<=0, return to IDLE.
- No new operands are accepted until the product is taken.
- Latency: accept to OUT_VALID = 2 + 2W + O_LAT cycles. Example W=4, O_LAT=1: 11 cycles.
- A_S, B_S and SCLR are registered outputs. O_S is sampled on the rising edge.
- Counter width is clog2(2W+O_LAT+1).
- Boundaries:
  - IN_VALID while not IDLE: ignored; IN_READY=0.
  - OUT_READY asserted outside DONE: no effect.
  - Operands 0 or all-ones: handled identically, with no early termination.
  - Reset in any state: immediate return to reset values; any partial product is discarded and SCLR is deasserted.

Optional Feature:
- Macro MULTI_HOST_CHECK_EN.
- Defined:
  - Adds output ERR (1 bit), a sticky register cleared only by reset.
  - Latches the operands and computes the reference a*b.
  - Sets ERR=1 in the cycle OUT_VALID rises if OUT_P != a*b.
  - The reference logic must not alter timing.
- Undefined: no ERR port and no reference multiplier; the datapath is identical otherwise.

Decomposition:
- Package multi_pkg holds:
  - state enum (IDLE, CLEAR, SHIFT, DONE)
  - default W and O_LAT constants
  - counter-width helper function
- One sub-module, multi_piso: loadable W-to-2W parallel-in/serial-out shift register. It is instantiated twice, for A and B.
- FSM, counter and product deserialiser stay in multi_host.

Test Plan:
- W=4, O_LAT=1, behavioural core model. IN_A=3, IN_B=5 -> SCLR pulse 1 cycle; A_S sequence 1,1,0,0,0,0,0,0; OUT_P=8'h0F, OUT_VALID 11 cycles after accept.
- IN_A=15, IN_B=15 -> OUT_P=8'hE1. IN_A=0, IN_B=9 -> OUT_P=8'h00 with the same latency.
- OUT_READY held low 20 cycles in DONE -> OUT_VALID and OUT_P stable, IN_READY=0, a second IN_VALID is ignored. OUT_READY=1 -> IDLE next cycle.
- Back-to-back: IN_VALID held high with OUT_READY=1 -> second operand pair accepted the cycle after DONE exits; products 3*5 then 7*6=8'h2A in order.
- RST dropped mid-SHIFT (cnt=3) -> all outputs at reset values immediately. A new pair 2*2 after release -> OUT_P=8'h04.
- With MULTI_HOST_CHECK_EN, a faulty core model that flips product bit 2 -> ERR=1 at OUT_VALID and stays set until reset.
